// File: rtl/vx_sau_seq.sv
// Sequenced N x N output-stationary systolic matrix-multiply unit: C = A x B or C += A x B,
// with A columns / B rows loaded over a valid/ready port and C returned row by row.
//   state   | meaning
//   S_IDLE  | waiting for a request; accumulators hold the last result
//   S_LOAD  | accepting N operand beats, bubbles inject zeros
//   S_DRAIN | 2N-1 cycles for the last beat to reach PE(N-1,N-1)
//   S_OUT   | returning result rows over the response port
module vx_sau_seq #(
    parameter int N         = 4,
    parameter int DATA_SIZE = 32,
    parameter int TAG_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_accum,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [N*DATA_SIZE-1:0] ld_a,
    input  logic [N*DATA_SIZE-1:0] ld_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [$clog2(N)-1:0]   rsp_row,
    output logic [N*DATA_SIZE-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    output logic                   rsp_last,
    output logic                   busy
);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0] K_LAST = CW'(N-1);
    localparam logic [CW-1:0] D_LAST = CW'(2*N-2);
    localparam logic [RW-1:0] R_LAST = RW'(N-1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

    state_t                 r_state, w_next;
    logic [CW-1:0]          r_cnt;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [RW-1:0]          r_row;
    logic [RW-1:0]          w_row_sel;
    logic                   r_rsp_valid, r_rsp_last;
    logic [N*DATA_SIZE-1:0] r_rsp_data, w_row_data;
    logic                   w_req_fire, w_ld_fire, w_rsp_fire, w_clr;

    logic [DATA_SIZE-1:0]   r_a_sk [N][N];
    logic [DATA_SIZE-1:0]   r_b_sk [N][N];
    logic [DATA_SIZE-1:0]   r_a_pe [N][N-1];
    logic [DATA_SIZE-1:0]   r_b_pe [N-1][N];
    logic [DATA_SIZE-1:0]   r_acc  [N][N];
    logic [DATA_SIZE-1:0]   w_a_in [N][N];
    logic [DATA_SIZE-1:0]   w_b_in [N][N];

    assign w_req_fire = (r_state == S_IDLE) && req_valid;
    assign w_ld_fire  = (r_state == S_LOAD) && ld_valid;
    assign w_rsp_fire = r_rsp_valid && rsp_ready;
    assign w_clr      = w_req_fire && !req_accum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        ld_ready  = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) w_next = S_LOAD;
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (w_ld_fire && r_cnt == K_LAST) w_next = S_DRAIN;
            end
            S_DRAIN: if (r_cnt == D_LAST) w_next = S_OUT;
            S_OUT:   if (w_rsp_fire && r_rsp_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shared beat / drain counter; restarts at 0 on each phase change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_LOAD:  if (w_ld_fire) r_cnt <= (r_cnt == K_LAST) ? '0 : r_cnt + CW'(1);
                S_DRAIN: r_cnt <= (r_cnt == D_LAST) ? '0 : r_cnt + CW'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_a_in[i][0] = r_a_sk[i][i];
            w_b_in[0][i] = r_b_sk[i][i];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                w_a_in[i][j] = r_a_pe[i][j-1];
                w_b_in[j][i] = r_b_pe[j-1][i];
            end
        end
    end

    // Skew chains and PE array shift every cycle; non-handshake cycles feed zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a_sk[i][j] <= '0;
                    r_b_sk[i][j] <= '0;
                    r_acc[i][j]  <= '0;
                end
                for (int j = 0; j < N-1; j++) r_a_pe[i][j] <= '0;
            end
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++) r_b_pe[i][j] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_a_sk[i][0] <= w_ld_fire ? ld_a[i*DATA_SIZE +: DATA_SIZE] : '0;
                r_b_sk[i][0] <= w_ld_fire ? ld_b[i*DATA_SIZE +: DATA_SIZE] : '0;
                for (int s = 1; s < N; s++) begin
                    r_a_sk[i][s] <= r_a_sk[i][s-1];
                    r_b_sk[i][s] <= r_b_sk[i][s-1];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++)
                    r_acc[i][j] <= w_clr ? '0 : r_acc[i][j] + w_a_in[i][j] * w_b_in[i][j];
                for (int j = 0; j < N-1; j++) r_a_pe[i][j] <= w_a_in[i][j];
            end
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++) r_b_pe[i][j] <= w_b_in[i][j];
        end
    end

    // While a row is presented, pre-select the next one so rows can stream back to back.
    assign w_row_sel = (r_rsp_valid && r_row != R_LAST) ? r_row + RW'(1) : r_row;

    always_comb begin
        w_row_data = '0;
        for (int j = 0; j < N; j++) w_row_data[j*DATA_SIZE +: DATA_SIZE] = r_acc[w_row_sel][j];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag       <= '0;
            r_row       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_req_fire) r_tag <= req_tag;
            if (r_state == S_OUT) begin
                if (!r_rsp_valid) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_row_data;
                    r_rsp_last  <= (r_row == R_LAST);
                end else if (rsp_ready) begin
                    if (r_rsp_last) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                        r_row       <= '0;
                    end else begin
                        r_row      <= w_row_sel;
                        r_rsp_data <= w_row_data;
                        r_rsp_last <= (w_row_sel == R_LAST);
                    end
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_row   = r_row;
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_tag;
    assign rsp_last  = r_rsp_last;

endmodule
